// File: rtl/instr_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and the control unit.
// slave is the decode stage's view; master is the view of the surrounding producer/consumer.
interface instr_decode_stage_if #(
  parameter int REG_AW   = 3,
  parameter int OFFSET_W = 8,
  parameter int AMT_W    = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instruction;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          opcode;
  logic [REG_AW-1:0]   writereg;
  logic [REG_AW-1:0]   readreg1;
  logic [REG_AW-1:0]   readreg2;
  logic [7:0]          immediate;
  logic [OFFSET_W-1:0] offset;
  logic [AMT_W-1:0]    amount;
  logic                illegal;

  modport slave (
    input  in_valid, instruction, out_ready,
    output in_ready, out_valid, opcode, writereg, readreg1, readreg2,
           immediate, offset, amount, illegal
  );

  modport master (
    output in_valid, instruction, out_ready,
    input  in_ready, out_valid, opcode, writereg, readreg1, readreg2,
           immediate, offset, amount, illegal
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered instruction field decoder with a 2-entry output buffer.
// Optional DECODE_STATS_EN adds saturating decoded/stall/illegal counters.
module instr_decode_stage #(
  parameter int REG_AW   = 3,
  parameter int OFFSET_W = 8,
  parameter int AMT_W    = 3,
  parameter int DEPTH    = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  instr_decode_stage_if.slave dec_if
`ifdef DECODE_STATS_EN
  ,
  output logic [15:0] stat_decoded_o,
  output logic [15:0] stat_stalls_o,
  output logic [7:0]  stat_illegal_o
`endif
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("instr_decode_stage: DEPTH must be 2");
  end

  typedef struct packed {
    logic [7:0]          opcode;
    logic [REG_AW-1:0]   writereg;
    logic [REG_AW-1:0]   readreg1;
    logic [REG_AW-1:0]   readreg2;
    logic [7:0]          immediate;
    logic [OFFSET_W-1:0] offset;
    logic [AMT_W-1:0]    amount;
    logic                illegal;
  } entry_t;

  entry_t     entry_q [2];
  entry_t     dec_d;
  logic       head_q;
  logic       tail_q;
  logic [1:0] count_q;
  logic       illegal_d;
  logic       push;
  logic       pop;

  // Unused high bits of the READREG1 byte mark the word as illegal.
  if (REG_AW == 8) begin : g_no_illegal
    assign illegal_d = 1'b0;
  end else begin : g_illegal
    assign illegal_d = |dec_if.instruction[15:8+REG_AW];
  end

  always_comb begin
    dec_d           = '0;
    dec_d.opcode    = dec_if.instruction[31:24];
    dec_d.writereg  = dec_if.instruction[16 +: REG_AW];
    dec_d.readreg1  = dec_if.instruction[8 +: REG_AW];
    dec_d.readreg2  = dec_if.instruction[0 +: REG_AW];
    dec_d.immediate = dec_if.instruction[7:0];
    dec_d.offset    = OFFSET_W'($signed(dec_if.instruction[23:16]));
    dec_d.amount    = dec_if.instruction[AMT_W-1:0];
    dec_d.illegal   = illegal_d;
  end

  assign dec_if.in_ready  = (count_q != 2'd2);
  assign dec_if.out_valid = (count_q != 2'd0);
  assign push = dec_if.in_valid & dec_if.in_ready;
  assign pop  = dec_if.out_valid & dec_if.out_ready;

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_q[gi] <= '0;
      end else if (push && !flush_i && (tail_q == 1'(gi))) begin
        entry_q[gi] <= dec_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush_i) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) tail_q <= ~tail_q;
      if (pop)  head_q <= ~head_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dec_if.opcode    = entry_q[head_q].opcode;
  assign dec_if.writereg  = entry_q[head_q].writereg;
  assign dec_if.readreg1  = entry_q[head_q].readreg1;
  assign dec_if.readreg2  = entry_q[head_q].readreg2;
  assign dec_if.immediate = entry_q[head_q].immediate;
  assign dec_if.offset    = entry_q[head_q].offset;
  assign dec_if.amount    = entry_q[head_q].amount;
  assign dec_if.illegal   = entry_q[head_q].illegal;

`ifdef DECODE_STATS_EN
  logic [15:0] stat_decoded_q;
  logic [15:0] stat_stalls_q;
  logic [7:0]  stat_illegal_q;

  // Counters survive FLUSH; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_decoded_q <= '0;
      stat_stalls_q  <= '0;
      stat_illegal_q <= '0;
    end else begin
      if (pop && (stat_decoded_q != '1))
        stat_decoded_q <= stat_decoded_q + 16'd1;
      if (dec_if.in_valid && !dec_if.in_ready && (stat_stalls_q != '1))
        stat_stalls_q <= stat_stalls_q + 16'd1;
      if (pop && entry_q[head_q].illegal && (stat_illegal_q != '1))
        stat_illegal_q <= stat_illegal_q + 8'd1;
    end
  end

  assign stat_decoded_o = stat_decoded_q;
  assign stat_stalls_o  = stat_stalls_q;
  assign stat_illegal_o = stat_illegal_q;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomised and directed checks of instr_decode_stage against a queue-based reference model.
module tb_instr_decode_stage;
  localparam int RW = 3;
  localparam int OW = 10;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] q [$];
  int stat_dec = 0;
  int stat_stall = 0;
  int stat_ill = 0;

  instr_decode_stage_if #(.REG_AW(RW), .OFFSET_W(OW), .AMT_W(AW)) bus ();

  instr_decode_stage #(.REG_AW(RW), .OFFSET_W(OW), .AMT_W(AW), .DEPTH(2)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .dec_if  (bus)
`ifdef DECODE_STATS_EN
    ,
    .stat_decoded_o (),
    .stat_stalls_o  (),
    .stat_illegal_o ()
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference field decode computed arithmetically from the word.
  function automatic int f_op(input logic [31:0] w);  return int'(w >> 24); endfunction
  function automatic int f_wr(input logic [31:0] w);  return int'((w >> 16) % (1 << RW)); endfunction
  function automatic int f_r1(input logic [31:0] w);  return int'((w >> 8) % (1 << RW)); endfunction
  function automatic int f_r2(input logic [31:0] w);  return int'(w % (1 << RW)); endfunction
  function automatic int f_imm(input logic [31:0] w); return int'(w % 256); endfunction
  function automatic int f_amt(input logic [31:0] w); return int'(w % (1 << AW)); endfunction
  function automatic int f_off(input logic [31:0] w);
    int b;
    b = int'((w >> 16) % 256);
    return (b >= 128) ? b + (1 << OW) - 256 : b;
  endfunction
  function automatic int f_ill(input logic [31:0] w);
    return ((((w >> 8) % 256) >> RW) != 0) ? 1 : 0;
  endfunction

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), (q.size() != 0) ? 32'd1 : 32'd0);
    check("in_ready",  32'(bus.in_ready),  (q.size() != 2) ? 32'd1 : 32'd0);
    if (q.size() != 0) begin
      check("opcode",    32'(bus.opcode),    32'(f_op(q[0])));
      check("writereg",  32'(bus.writereg),  32'(f_wr(q[0])));
      check("readreg1",  32'(bus.readreg1),  32'(f_r1(q[0])));
      check("readreg2",  32'(bus.readreg2),  32'(f_r2(q[0])));
      check("immediate", 32'(bus.immediate), 32'(f_imm(q[0])));
      check("offset",    32'(bus.offset),    32'(f_off(q[0])));
      check("amount",    32'(bus.amount),    32'(f_amt(q[0])));
      check("illegal",   32'(bus.illegal),   32'(f_ill(q[0])));
    end
`ifdef DECODE_STATS_EN
    check("stat_decoded", 32'(dut.stat_decoded_o), 32'(stat_dec));
    check("stat_stalls",  32'(dut.stat_stalls_o),  32'(stat_stall));
    check("stat_illegal", 32'(dut.stat_illegal_o), 32'(stat_ill));
`endif
  endtask

  // One cycle: check at negedge, drive, then advance the model at the posedge.
  task automatic step(input bit v, input logic [31:0] w, input bit ordy, input bit fl);
    bit do_push;
    bit do_pop;
    @(negedge clk);
    check_outputs();
    bus.in_valid    = v;
    bus.instruction = w;
    bus.out_ready   = ordy;
    flush           = fl;
    do_push = v && (q.size() < 2);
    do_pop  = ordy && (q.size() > 0);
    @(posedge clk);
    if (v && q.size() == 2 && stat_stall < 65535) stat_stall++;
    if (do_pop) begin
      if (stat_dec < 65535) stat_dec++;
      if (f_ill(q[0]) != 0 && stat_ill < 255) stat_ill++;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(w);
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.instruction = '0;
    bus.out_ready   = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_opcode",    32'(bus.opcode),    32'd0);
    check("rst_offset",    32'(bus.offset),    32'd0);
    check("rst_illegal",   32'(bus.illegal),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic decode
    step(1, 32'h0A050203, 1, 0);
    #1;
    check("basic_valid", 32'(bus.out_valid), 32'd1);
    check("basic_op",    32'(bus.opcode),    32'h0A);
    check("basic_wr",    32'(bus.writereg),  32'd5);
    check("basic_r1",    32'(bus.readreg1),  32'd2);
    check("basic_r2",    32'(bus.readreg2),  32'd3);
    check("basic_imm",   32'(bus.immediate), 32'h03);
    check("basic_off",   32'(bus.offset),    32'h005);
    check("basic_amt",   32'(bus.amount),    32'd3);
    check("basic_ill",   32'(bus.illegal),   32'd0);

    // Sign extension
    step(1, 32'h00FC0000, 1, 0);
    #1 check("sext_neg", 32'(bus.offset), 32'h3FC);
    step(1, 32'h007F0000, 1, 0);
    #1 check("sext_pos", 32'(bus.offset), 32'h07F);
    step(0, 32'h0, 1, 0);

    // Illegal flag
    step(1, 32'h00000A00, 1, 0);
    #1;
    check("ill_flag", 32'(bus.illegal),  32'd1);
    check("ill_r1",   32'(bus.readreg1), 32'd2);
    step(0, 32'h0, 1, 0);

    // Backpressure: A, B fill; C held off until space opens
    step(1, 32'hA1000001, 0, 0);
    step(1, 32'hB2000002, 0, 0);
    #1 check("full_ready", 32'(bus.in_ready), 32'd0);
    step(1, 32'hC3000003, 0, 0);
    step(1, 32'hC3000003, 1, 0);
    step(1, 32'hC3000003, 1, 0);
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);

    // Simultaneous push/pop at count=1
    step(1, 32'h11223344, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, $urandom, 1, 0);
      #1;
      check("pp_valid", 32'(bus.out_valid), 32'd1);
      check("pp_ready", 32'(bus.in_ready),  32'd1);
    end
    step(0, 32'h0, 1, 0);

    // Flush at count=2 with push, then at count=1 with an accepted push
    step(1, 32'h01010101, 0, 0);
    step(1, 32'h02020202, 0, 0);
    step(1, 32'h03030303, 1, 1);
    #1;
    check("flush2_valid", 32'(bus.out_valid), 32'd0);
    check("flush2_ready", 32'(bus.in_ready),  32'd1);
    step(1, 32'h04040404, 0, 0);
    step(1, 32'h05050505, 0, 1);
    #1 check("flush1_valid", 32'(bus.out_valid), 32'd0);
    step(0, 32'h0, 1, 0);

    // Asynchronous reset at count=2, between edges
    step(1, 32'h0A0A0A0A, 0, 0);
    step(1, 32'h0B0B0B0B, 0, 0);
    #2;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("arst_valid",  32'(bus.out_valid), 32'd0);
    check("arst_ready",  32'(bus.in_ready),  32'd1);
    check("arst_opcode", 32'(bus.opcode),    32'd0);
`ifdef DECODE_STATS_EN
    check("arst_stat_dec", 32'(dut.stat_decoded_o), 32'd0);
    check("arst_stat_stl", 32'(dut.stat_stalls_o),  32'd0);
    check("arst_stat_ill", 32'(dut.stat_illegal_o), 32'd0);
`endif
    q.delete();
    stat_dec   = 0;
    stat_stall = 0;
    stat_ill   = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 4) != 0, $urandom, $urandom % 2, ($urandom % 32) == 0);
    end
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
